// File: rtl/fsm_moore_led_seq.sv
// Moore LED sequencer: synchronised, debounced switches walk a one-hot LED chain to an ALL state.
// Optional ALL-state blink is enabled by defining FSM_LED_BLINK_EN.
module fsm_moore_led_seq #(
    parameter int WIDTH      = 3,
    parameter int STABLE_CYC = 4,
    parameter int BLINK_DIV  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              sw,
    output logic [WIDTH-1:0]              led,
    output logic [$clog2(WIDTH+2)-1:0]    state,
    output logic                          step_pulse
);
    localparam int STW = $clog2(WIDTH+2);
    localparam int CW  = $clog2(STABLE_CYC+1);

    typedef enum logic [STW-1:0] {
        S_IDLE  = STW'(0),
        S_STEP0 = STW'(1),
        S_ALL   = STW'(WIDTH+1)
    } state_t;

    localparam logic [STW-1:0]   C_LAST   = STW'(WIDTH);
    localparam logic [STW-1:0]   C_STEP1  = STW'(2);
    localparam logic [WIDTH-1:0] C_ONES   = '1;
    localparam logic [WIDTH-1:0] C_PAIR   = WIDTH'(3);
    localparam logic [WIDTH-1:0] C_OH0    = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_OH1    = WIDTH'(2);
    localparam logic [CW-1:0]    C_STABLE = CW'(STABLE_CYC);

    logic [WIDTH-1:0] r_sync1, r_sync2, r_last, r_sw_q;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nx;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_led, w_led_nx, w_all_led;
    logic             r_pulse;

    // r_last holds the previous sw_s sample; the run length restarts at 1 on any change
    always_comb begin
        w_cnt_nx = CW'(1);
        if (r_sync2 == r_last)
            w_cnt_nx = (r_cnt == C_STABLE) ? r_cnt : r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
            r_sw_q  <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
            r_cnt   <= w_cnt_nx;
            if (w_cnt_nx >= C_STABLE)
                r_sw_q <= r_sync2;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) begin
            if (r_sw_q == C_OH0)
                w_next = S_STEP0;
            else if (r_sw_q == C_OH1)
                w_next = state_t'(C_STEP1);
        end else if (r_state == S_ALL) begin
            if (r_sw_q == '0)
                w_next = S_IDLE;
        end else if (r_state > S_ALL) begin
            w_next = S_IDLE;
        end else if (r_state == C_LAST) begin
            if (r_sw_q == '0)
                w_next = S_IDLE;
            else if (r_sw_q == C_ONES)
                w_next = S_ALL;
            else if (r_sw_q == C_PAIR)
                w_next = S_STEP0;
        end else begin
            // STEP_i has code i+1, so OH(i+1) is 1 << code
            if (r_sw_q == (C_OH0 << r_state))
                w_next = state_t'(STW'(r_state) + STW'(1));
            else if (r_sw_q == '0)
                w_next = S_IDLE;
        end
    end

`ifdef FSM_LED_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV+1);
    logic [BW-1:0] r_bcnt, w_bcnt_nx;
    logic          r_bph, w_bph_nx;

    always_comb begin
        w_bcnt_nx = '0;
        w_bph_nx  = 1'b0;
        if (r_state == S_ALL && w_next == S_ALL) begin
            if (r_bcnt == BW'(BLINK_DIV-1)) begin
                w_bcnt_nx = '0;
                w_bph_nx  = ~r_bph;
            end else begin
                w_bcnt_nx = r_bcnt + BW'(1);
                w_bph_nx  = r_bph;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcnt <= '0;
            r_bph  <= 1'b0;
        end else begin
            r_bcnt <= w_bcnt_nx;
            r_bph  <= w_bph_nx;
        end
    end

    assign w_all_led = w_bph_nx ? '0 : C_ONES;
`else
    assign w_all_led = C_ONES;
`endif

    // led is decoded from the next state so it registers on the same edge as state
    always_comb begin
        w_led_nx = '0;
        if (w_next == S_ALL)
            w_led_nx = w_all_led;
        else if (w_next != S_IDLE)
            w_led_nx = C_OH0 << (STW'(w_next) - STW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_next;
            r_led   <= w_led_nx;
            r_pulse <= (w_next != r_state);
        end
    end

    assign led        = r_led;
    assign state      = r_state;
    assign step_pulse = r_pulse;
endmodule

// File: tb/tb_fsm_moore_led_seq.sv
// Bench for fsm_moore_led_seq: vector table, hand sequences and random stimulus vs a window/step model.
module tb_fsm_moore_led_seq;
    localparam int W  = 3;
    localparam int SC = 4;
    localparam int BD = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] led;
    logic [$clog2(W+2)-1:0] state;
    logic         step_pulse;

    int checks = 0;
    int errors = 0;

    fsm_moore_led_seq #(.WIDTH(W), .STABLE_CYC(SC), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .sw(sw),
        .led(led), .state(state), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sw;
        int           hold;
        logic [W-1:0] led;
        int           st;
    } vec_t;
    vec_t vt[13];

    // model: kind 0=IDLE 1=STEP(idx) 2=ALL
    int           m_kind, m_idx, m_pulse, m_all_cyc;
    logic [W-1:0] m_swq;
    logic [W-1:0] hq[$];
    logic [W-1:0] ones;

    function automatic int m_code();
        if (m_kind == 0) return 0;
        if (m_kind == 1) return m_idx + 1;
        return W + 1;
    endfunction

    function automatic int m_led();
        if (m_kind == 0) return 0;
        if (m_kind == 1) return 1 << m_idx;
`ifdef FSM_LED_BLINK_EN
        if (((m_all_cyc / BD) % 2) == 1) return 0;
`endif
        return int'(ones);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        repeat (SC + 2) hq.push_back('0);
        m_kind = 0; m_idx = 0; m_pulse = 0; m_all_cyc = 0; m_swq = '0;
    endtask

    task automatic model_edge();
        int pk, pi, n;
        bit same;
        pk = m_kind; pi = m_idx;
        case (m_kind)
            0: begin
                if (m_swq == 1)      begin m_kind = 1; m_idx = 0; end
                else if (m_swq == 2) begin m_kind = 1; m_idx = 1; end
            end
            1: begin
                if (m_idx < W - 1) begin
                    if (int'(m_swq) == (1 << (m_idx + 1))) m_idx = m_idx + 1;
                    else if (m_swq == 0) begin m_kind = 0; m_idx = 0; end
                end else begin
                    if (m_swq == 0)         begin m_kind = 0; m_idx = 0; end
                    else if (m_swq == ones) begin m_kind = 2; m_idx = 0; end
                    else if (m_swq == 3)    m_idx = 0;
                end
            end
            default: if (m_swq == 0) begin m_kind = 0; m_idx = 0; end
        endcase
        m_pulse = (m_kind != pk || m_idx != pi) ? 1 : 0;
        m_all_cyc = (m_kind == 2 && pk == 2) ? m_all_cyc + 1 : 0;
        // sw_s seen at this edge is the raw value from two edges ago; accept after SC equal samples
        hq.push_back(sw);
        n = hq.size();
        same = 1;
        for (int k = n - 2 - SC; k < n - 3; k++)
            if (hq[k] != hq[n-3]) same = 0;
        if (same) m_swq = hq[n-3];
        void'(hq.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("led", int'(led), m_led());
        chk("state", int'(state), m_code());
        chk("step_pulse", int'(step_pulse), m_pulse);
    endtask

    // called at a negedge; asserts reset mid-cycle and checks the asynchronous clear
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_led", int'(led), 0);
        chk("async_state", int'(state), 0);
        chk("async_pulse", int'(step_pulse), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_led", int'(led), 0);
        chk("rst_hold_state", int'(state), 0);
        reset = 1'b0;
    endtask

    initial begin
        ones = '1;
        vt[0]  = '{3'b001, 10, 3'b001, 1};
        vt[1]  = '{3'b010, 10, 3'b010, 2};
        vt[2]  = '{3'b100, 10, 3'b100, 3};
        vt[3]  = '{3'b111, 10, 3'b111, 4};
        vt[4]  = '{3'b000, 10, 3'b000, 0};
        vt[5]  = '{3'b010, 10, 3'b010, 2};
        vt[6]  = '{3'b000, 10, 3'b000, 0};
        vt[7]  = '{3'b001, 10, 3'b001, 1};
        vt[8]  = '{3'b010, 10, 3'b010, 2};
        vt[9]  = '{3'b100, 10, 3'b100, 3};
        vt[10] = '{3'b011, 10, 3'b001, 1};
        vt[11] = '{3'b100, 10, 3'b001, 1};
        vt[12] = '{3'b000, 10, 3'b000, 0};

        // reset with all switches on, then keep them on: 111 is not a valid move from IDLE
        sw = 3'b111;
        @(negedge clk);
        apply_reset();
        repeat (12) tick();
        chk("sw111_idle_state", int'(state), 0);

        for (int i = 0; i < 13; i++) begin
            sw = vt[i].sw;
            repeat (vt[i].hold) tick();
            chk($sformatf("vec%0d_led", i), int'(led), int'(vt[i].led));
            chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
        end

        // first move lands on exactly the 7th edge
        apply_reset();
        sw = 3'b001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e < 7) begin
                chk($sformatf("lat_e%0d_state", e), int'(state), 0);
                chk($sformatf("lat_e%0d_pulse", e), int'(step_pulse), 0);
            end else if (e == 7) begin
                chk("lat_e7_led", int'(led), 1);
                chk("lat_e7_state", int'(state), 1);
                chk("lat_e7_pulse", int'(step_pulse), 1);
            end else begin
                chk("lat_e8_pulse", int'(step_pulse), 0);
                chk("lat_e8_state", int'(state), 1);
            end
        end

        // a 3-cycle glitch never gets through the debouncer
        apply_reset();
        sw = 3'b010;
        repeat (3) tick();
        sw = 3'b000;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk("glitch_led", int'(led), 0);
            chk("glitch_pulse", int'(step_pulse), 0);
        end

        // climb to ALL, then reset mid-cycle
        sw = 3'b001; repeat (10) tick();
        sw = 3'b010; repeat (10) tick();
        sw = 3'b100; repeat (10) tick();
        sw = 3'b111; repeat (10) tick();
        chk("all_state", int'(state), W + 1);
        apply_reset();
        sw = 3'b000;

        for (int s = 0; s < 350; s++) begin
            case ($urandom_range(0, 7))
                0:       sw = '0;
                1:       sw = '1;
                2:       sw = 3'b011;
                3, 4, 5: sw = W'(1 << $urandom_range(0, W - 1));
                default: sw = W'($urandom);
            endcase
            repeat ($urandom_range(1, 12)) tick();
            if ($urandom_range(0, 39) == 0) apply_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
